// File: rtl/vx_pipe_sched.sv
// Round-robin issue scheduler for a shared fixed-latency, enable-gated datapath (optional perf counters: VX_PIPE_SCHED_PERF_EN).
// Latency: DEPTH cycles from accept to rsp_valid; one issue and one retire per cycle.
// Backpressure: rsp_ready low with a valid result freezes the whole chain and drops all req_ready.
module vx_pipe_sched #(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 32,
    parameter int DEPTH    = 3,
    parameter int TAGW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       req_valid,
    input  logic [NUM_REQS*DATAW-1:0] req_data,
    output logic [NUM_REQS-1:0]       req_ready,
    output logic                      pipe_enable,
    output logic [DATAW-1:0]          pipe_data_in,
    input  logic [DATAW-1:0]          pipe_data_out,
    output logic                      rsp_valid,
    output logic [DATAW-1:0]          rsp_data,
    output logic [TAGW-1:0]           rsp_tag,
    input  logic                      rsp_ready
`ifdef VX_PIPE_SCHED_PERF_EN
    ,
    output logic [31:0]               perf_issued,
    output logic [31:0]               perf_stalls
`endif
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("vx_pipe_sched: DEPTH must be >= 1");
    end
    if (NUM_REQS < 1 || NUM_REQS > 16) begin : g_bad_reqs
        $error("vx_pipe_sched: NUM_REQS must be in 1..16");
    end

    logic [DEPTH-1:0]           vld_q, vld_d;
    logic [DEPTH-1:0][TAGW-1:0] tag_q, tag_d;
    logic [TAGW-1:0]            rr_q, rr_d;
    logic [TAGW-1:0]            grant_idx;
    logic                       any_valid;
    logic                       fire;

    // Walk candidates from farthest to nearest so the nearest valid one from rr wins.
    always_comb begin : p_arb
        logic [TAGW:0] cand;
        cand      = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        for (int off = NUM_REQS - 1; off >= 0; off--) begin
            cand = {1'b0, rr_q} + (TAGW+1)'(off);
            if (cand >= (TAGW+1)'(NUM_REQS)) begin
                cand = cand - (TAGW+1)'(NUM_REQS);
            end
            if (req_valid[cand[TAGW-1:0]]) begin
                grant_idx = cand[TAGW-1:0];
                any_valid = 1'b1;
            end
        end
    end

    assign pipe_enable = !(vld_q[DEPTH-1] && !rsp_ready);

    always_comb begin
        req_ready    = '0;
        pipe_data_in = req_data[DATAW-1:0];
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant_idx == TAGW'(i)) begin
                req_ready[i] = pipe_enable && any_valid;
                pipe_data_in = req_data[i*DATAW +: DATAW];
            end
        end
    end

    assign fire = (|(req_valid & req_ready)) && !reset;

    always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        rr_d  = rr_q;
        if (pipe_enable) begin
            for (int s = DEPTH - 1; s > 0; s--) begin
                vld_d[s] = vld_q[s-1];
                tag_d[s] = tag_q[s-1];
            end
            vld_d[0] = fire;
            tag_d[0] = grant_idx;
        end
        if (fire) begin
            rr_d = (grant_idx == TAGW'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            rr_q  <= '0;
        end else begin
            vld_q <= vld_d;
            rr_q  <= rr_d;
        end
    end

    // Tags travel with vld and are only observed when vld is set, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
    end

    assign rsp_valid = vld_q[DEPTH-1];
    assign rsp_tag   = tag_q[DEPTH-1];
    assign rsp_data  = pipe_data_out;

`ifdef VX_PIPE_SCHED_PERF_EN
    logic [31:0] perf_issued_q, perf_stalls_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_issued_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (fire) begin
                perf_issued_q <= perf_issued_q + 32'd1;
            end
            if (!pipe_enable && (|req_valid)) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_vx_pipe_sched.sv
// Bench for vx_pipe_sched: random requesters plus an event-count reference model, and directed literal checks.
module tb_vx_pipe_sched;
    localparam int NR    = 4;
    localparam int DATAW = 32;
    localparam int DEPTH = 3;
    localparam int TAGW  = 2;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NR-1:0]          req_valid = '0;
    logic [NR*DATAW-1:0]    req_data = '0;
    logic [NR-1:0]          req_ready;
    logic                   pipe_enable;
    logic [DATAW-1:0]       pipe_data_in;
    logic [DATAW-1:0]       pipe_data_out;
    logic                   rsp_valid;
    logic [DATAW-1:0]       rsp_data;
    logic [TAGW-1:0]        rsp_tag;
    logic                   rsp_ready = 1'b1;
`ifdef VX_PIPE_SCHED_PERF_EN
    logic [31:0]            perf_issued;
    logic [31:0]            perf_stalls;
`endif

    vx_pipe_sched #(.NUM_REQS(NR), .DATAW(DATAW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .pipe_enable(pipe_enable), .pipe_data_in(pipe_data_in), .pipe_data_out(pipe_data_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready)
`ifdef VX_PIPE_SCHED_PERF_EN
        , .perf_issued(perf_issued), .perf_stalls(perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    // Identity datapath: DEPTH enable-gated registers without reset.
    logic [DATAW-1:0] stg [DEPTH];
    always @(posedge clk) begin
        if (pipe_enable) begin
            stg[0] <= pipe_data_in;
            for (int s = 1; s < DEPTH; s++) stg[s] <= stg[s-1];
        end
    end
    assign pipe_data_out = stg[DEPTH-1];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each entry remembers the enabled-edge count at which it issued and
    // reaches the output DEPTH-1 enabled edges later; stalls simply stop that count.
    typedef struct {
        int               tag;
        logic [DATAW-1:0] dat;
        int               ts;
    } ent_t;
    ent_t        q[$];
    int          obs_tags[$];
    int          obs_grant[$];
    int          m_rr = 0;
    int          ecnt = 0;
    bit          mdl_ok = 0;
    logic [NR-1:0] acc = '0;
    int          m_issued = 0;
    int          m_stalls = 0;

    always @(negedge clk) begin
        bit ev, een, any;
        int g, idx;
        logic [NR-1:0] exp_rdy;
        ev  = (q.size() > 0) && (q[0].ts + DEPTH - 1 == ecnt);
        een = !(ev && !rsp_ready);
        any = 0;
        g   = 0;
        for (int off = 0; off < NR; off++) begin
            idx = (m_rr + off) % NR;
            if (req_valid[idx] && !any) begin
                any = 1;
                g   = idx;
            end
        end
        exp_rdy = (een && any) ? NR'(1 << g) : '0;
        if (mdl_ok) begin
            check("rsp_valid", 64'(rsp_valid), 64'(ev));
            check("pipe_enable", 64'(pipe_enable), 64'(een));
            check("req_ready", 64'(req_ready), 64'(exp_rdy));
            if (een && any) check("pipe_data_in", 64'(pipe_data_in), 64'(req_data[g*DATAW +: DATAW]));
            if (ev) begin
                check("rsp_tag", 64'(rsp_tag), 64'(q[0].tag));
                check("rsp_data", 64'(rsp_data), 64'(q[0].dat));
            end
`ifdef VX_PIPE_SCHED_PERF_EN
            check("perf_issued", 64'(perf_issued), 64'(m_issued));
            check("perf_stalls", 64'(perf_stalls), 64'(m_stalls));
`endif
        end
        if (reset) begin
            q.delete();
            m_rr = 0;
            ecnt = 0;
            acc = '0;
            m_issued = 0;
            m_stalls = 0;
            mdl_ok = 1;
        end else begin
            acc = req_valid & req_ready;
            if (ev && rsp_ready) begin
                obs_tags.push_back(q[0].tag);
                void'(q.pop_front());
            end
            if (!een && (|req_valid)) m_stalls++;
            if (een) begin
                ecnt++;
                if (any) begin
                    q.push_back('{g, req_data[g*DATAW +: DATAW], ecnt});
                    obs_grant.push_back(g);
                    m_rr = (g + 1) % NR;
                    m_issued++;
                end
            end
        end
    end

    bit          gen_on = 0;
    logic [NR-1:0] gen_mask = '1;
    int          gen_pct = 100;
    int          drop_pct = 0;
    int          rdy_pct = 100;

    // One clock step; random requesters hold valid/data until accepted unless they drop out.
    task automatic tick();
        @(posedge clk);
        #1;
        if (gen_on) begin
            for (int i = 0; i < NR; i++) begin
                if (!gen_mask[i]) req_valid[i] = 1'b0;
                else if (req_valid[i] && !acc[i]) begin
                    if (int'($urandom_range(99)) < drop_pct) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = int'($urandom_range(99)) < gen_pct;
                    req_data[i*DATAW +: DATAW] = $urandom();
                end
            end
        end
        rsp_ready = int'($urandom_range(99)) < rdy_pct;
    endtask

    function automatic int pick(input int qq[$], input int k);
        return (qq.size() > k) ? qq[k] : 99;
    endfunction

    initial begin
        int n;
        int fair_exp[5] = '{0, 1, 2, 3, 0};
        int sparse_exp[3] = '{2, 3, 0};

        // Reset state; req_ready is combinational even in reset.
        repeat (2) tick();
        req_valid = 4'b0010;
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_pipe_enable", 64'(pipe_enable), 64'd1);
        check("rst_req_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        reset = 1'b0;

        // Single issue from requester 2.
        req_valid = 4'b0100;
        req_data[2*DATAW +: DATAW] = 32'hA5;
        @(negedge clk);
        check("si_ready", 64'(req_ready), 64'h4);
        tick();
        req_valid = '0;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n++;
            if (rsp_valid) break;
        end
        check("si_latency", 64'(n), 64'(DEPTH));
        check("si_tag", 64'(rsp_tag), 64'd2);
        check("si_data", 64'(rsp_data), 64'hA5);
        tick();

        // Fairness: all requesters always valid.
        gen_on = 1; gen_mask = '1; gen_pct = 100; drop_pct = 0; rdy_pct = 100;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        obs_tags.delete();
        obs_grant.delete();
        repeat (12) tick();
        for (int k = 0; k < 5; k++) begin
            check("fair_grant", 64'(pick(obs_grant, k)), 64'(fair_exp[k]));
            check("fair_tag", 64'(pick(obs_tags, k)), 64'(fair_exp[k]));
        end
        check("fair_rate", 64'(obs_tags.size() >= 8), 64'd1);

        // Back-pressure on a full pipe for 5 cycles.
        rdy_pct = 0;
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_enable", 64'(pipe_enable), 64'd0);
            check("bp_ready", 64'(req_ready), 64'd0);
            if (k == 4) rdy_pct = 100;
            tick();
        end
        repeat (10) tick();

        // Sparse with wrap: 2, bubble, then 3 and 0 both valid.
        gen_on = 0;
        req_valid = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        obs_tags.delete();
        req_valid = 4'b0100;
        req_data[2*DATAW +: DATAW] = 32'h22;
        @(negedge clk);
        check("sp_ready2", 64'(req_ready), 64'h4);
        tick();
        req_valid = '0;
        tick();
        req_valid = 4'b1001;
        req_data[3*DATAW +: DATAW] = 32'h33;
        req_data[0 +: DATAW] = 32'h11;
        @(negedge clk);
        check("sp_ready3", 64'(req_ready), 64'h8);
        tick();
        req_valid = 4'b0001;
        @(negedge clk);
        check("sp_ready0", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        repeat (6) tick();
        for (int k = 0; k < 3; k++) check("sp_tag", 64'(pick(obs_tags, k)), 64'(sparse_exp[k]));

        // Reset with entries in flight.
        gen_on = 1; gen_mask = '1; gen_pct = 100;
        repeat (4) tick();
        gen_on = 0;
        req_valid = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < DEPTH + 2; k++) begin
            @(negedge clk);
            check("mr_quiet", 64'(rsp_valid), 64'd0);
            tick();
        end
        req_valid = '1;
        @(negedge clk);
        check("mr_first", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;

        // Random soak with drop-outs and random back-pressure.
        gen_on = 1; gen_mask = '1; gen_pct = 50; drop_pct = 5; rdy_pct = 70;
        repeat (3000) tick();
        gen_on = 0;
        req_valid = '0;
        rdy_pct = 100;
        repeat (DEPTH + 5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
